// File: rtl/core_ex_bj_resolve.sv
// core_ex_bj_resolve: EX-stage branch/jump resolution, redirect handshake to IF,
// bimodal 2-bit branch history table and saturating mispredict counter.
`default_nettype none

module core_ex_bj_resolve #(
   parameter int XLEN      = 32,
   parameter int PC_WIDTH  = 32,
   parameter int BHT_DEPTH = 64,
   parameter int IDX_LSB   = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ex_valid,
   input  logic [7:0]          bj_op,
   input  logic [PC_WIDTH-1:0] pc,
   input  logic [XLEN-1:0]     imm,
   input  logic [XLEN-1:0]     rs1,
   input  logic [XLEN-1:0]     rs2,
   input  logic                pred_taken,
   input  logic [PC_WIDTH-1:0] pred_pc,
   output logic                ex_stall,
   output logic                redirect_valid,
   output logic [PC_WIDTH-1:0] redirect_pc,
   input  logic                redirect_ready,
   output logic                misalign_err,
   input  logic [PC_WIDTH-1:0] if_pc,
   output logic                if_pred_taken,
   output logic [31:0]         mispredict_cnt
);

   localparam int         IDX_W    = $clog2(BHT_DEPTH);
   localparam logic [1:0] CTR_INIT = 2'b01;
   localparam logic [1:0] CTR_MAX  = 2'b11;
   localparam logic [1:0] CTR_MIN  = 2'b00;

   logic                redirect_valid_q, redirect_valid_d;
   logic [PC_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
   logic                misalign_q, misalign_d;
   logic [31:0]         cnt_q, cnt_d;
   logic [1:0]          bht_q [BHT_DEPTH];

   logic                resolve;
   logic                is_eq, is_lt, is_ltu;
   logic                taken;
   logic [XLEN-1:0]     pc_ext;
   logic [XLEN-1:0]     jalr_sum;
   logic [XLEN-1:0]     target_full;
   logic [PC_WIDTH-1:0] target;
   logic [PC_WIDTH-1:0] seq_pc;
   logic [PC_WIDTH-1:0] next_pc;
   logic                mispredict;
   logic                misalign;
   logic                do_redirect;
   logic                bht_upd;
   logic [IDX_W-1:0]    wr_idx;
   logic [IDX_W-1:0]    rd_idx;
   logic [1:0]          ctr_cur, ctr_d;
   logic                unused_ok;

   assign ex_stall = redirect_valid_q & ~redirect_ready;
   assign resolve  = ex_valid & (|bj_op) & ~ex_stall;

   assign is_eq  = (rs1 == rs2);
   assign is_lt  = ($signed(rs1) < $signed(rs2));
   assign is_ltu = (rs1 < rs2);

   assign taken = bj_op[0] | bj_op[1]
                | (bj_op[2] &  is_eq)  | (bj_op[3] & ~is_eq)
                | (bj_op[4] &  is_lt)  | (bj_op[5] & ~is_lt)
                | (bj_op[6] &  is_ltu) | (bj_op[7] & ~is_ltu);

   // Targets are formed at XLEN and then truncated to the PC width.
   assign pc_ext      = XLEN'(pc);
   assign jalr_sum    = rs1 + imm;
   assign target_full = bj_op[1] ? (jalr_sum & ~XLEN'(1)) : (pc_ext + imm);
   assign target      = target_full[PC_WIDTH-1:0];
   assign seq_pc      = pc + PC_WIDTH'(4);
   assign next_pc     = taken ? target : seq_pc;

   assign mispredict  = (taken != pred_taken) | (taken & (pred_pc != target));
   assign misalign    = taken & target[1];
   assign do_redirect = resolve & ~misalign & mispredict;
   assign bht_upd     = resolve & ~misalign & (|bj_op[7:2]);

   assign wr_idx  = pc[IDX_LSB +: IDX_W];
   assign rd_idx  = if_pc[IDX_LSB +: IDX_W];
   assign ctr_cur = bht_q[wr_idx];

   always_comb begin
      ctr_d = ctr_cur;
      if (taken) begin
         if (ctr_cur != CTR_MAX) ctr_d = ctr_cur + 2'd1;
      end else begin
         if (ctr_cur != CTR_MIN) ctr_d = ctr_cur - 2'd1;
      end
   end

   // A new mispredict can only resolve when the held redirect is being accepted.
   always_comb begin
      redirect_valid_d = redirect_valid_q;
      redirect_pc_d    = redirect_pc_q;
      cnt_d            = cnt_q;
      misalign_d       = resolve & misalign;
      if (do_redirect) begin
         redirect_valid_d = 1'b1;
         redirect_pc_d    = next_pc;
         if (cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
      end else if (redirect_ready) begin
         redirect_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         misalign_q       <= 1'b0;
         cnt_q            <= '0;
      end else begin
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         misalign_q       <= misalign_d;
         cnt_q            <= cnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= CTR_INIT;
      end else if (bht_upd) begin
         bht_q[wr_idx] <= ctr_d;
      end
   end

   // No write bypass: a same-cycle lookup sees the pre-update counter.
   assign if_pred_taken  = bht_q[rd_idx][1];
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign misalign_err   = misalign_q;
   assign mispredict_cnt = cnt_q;

   assign unused_ok = ^{if_pc, target_full};

endmodule

`default_nettype wire

// File: tb/tb_core_ex_bj_resolve.sv
// tb_core_ex_bj_resolve: directed vectors with a redirect/misalign scoreboard.
`default_nettype none

module tb_core_ex_bj_resolve;

   localparam logic [7:0] OP_JAL  = 8'h01;
   localparam logic [7:0] OP_JALR = 8'h02;
   localparam logic [7:0] OP_BEQ  = 8'h04;
   localparam logic [7:0] OP_BNE  = 8'h08;
   localparam logic [7:0] OP_BLT  = 8'h10;
   localparam logic [7:0] OP_BGE  = 8'h20;
   localparam logic [7:0] OP_BLTU = 8'h40;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid;
   logic [7:0]  bj_op;
   logic [31:0] pc, imm, rs1, rs2;
   logic        pred_taken;
   logic [31:0] pred_pc;
   logic        ex_stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_ready;
   logic        misalign_err;
   logic [31:0] if_pc;
   logic        if_pred_taken;
   logic [31:0] mispredict_cnt;

   typedef struct {
      bit          is_mis;
      logic [31:0] npc;
   } exp_t;

   exp_t exp_q[$];
   int   n_pass  = 0;
   int   n_total = 0;

   core_ex_bj_resolve dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ex_valid      (ex_valid),
      .bj_op         (bj_op),
      .pc            (pc),
      .imm           (imm),
      .rs1           (rs1),
      .rs2           (rs2),
      .pred_taken    (pred_taken),
      .pred_pc       (pred_pc),
      .ex_stall      (ex_stall),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .redirect_ready(redirect_ready),
      .misalign_err  (misalign_err),
      .if_pc         (if_pc),
      .if_pred_taken (if_pred_taken),
      .mispredict_cnt(mispredict_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(posedge clk) begin
      if (rst_n && ex_valid)
         assert ($onehot0(bj_op)) else $error("bj_op not one-hot: %b", bj_op);
   end

   // Monitor: pops an expectation for each misalign pulse and each accepted redirect.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (misalign_err) begin
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_misalign: got 1 expected 0");
            end else begin
               e = exp_q.pop_front();
               check("misalign_kind", 64'(e.is_mis), 64'd1);
            end
         end
         if (redirect_valid && redirect_ready) begin
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_redirect: got pc %0h expected none", redirect_pc);
            end else begin
               e = exp_q.pop_front();
               check("redirect_kind", 64'(e.is_mis), 64'd0);
               check("redirect_pc", 64'(redirect_pc), 64'(e.npc));
            end
         end
      end
   end

   task automatic push_redirect(input logic [31:0] npc);
      exp_t e;
      e.is_mis = 1'b0;
      e.npc    = npc;
      exp_q.push_back(e);
   endtask

   task automatic push_misalign();
      exp_t e;
      e.is_mis = 1'b1;
      e.npc    = '0;
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic [7:0] op, input logic [31:0] p, input logic [31:0] im,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic pt, input logic [31:0] ppc);
      ex_valid   = 1'b1;
      bj_op      = op;
      pc         = p;
      imm        = im;
      rs1        = a;
      rs2        = b;
      pred_taken = pt;
      pred_pc    = ppc;
   endtask

   task automatic issue(input logic [7:0] op, input logic [31:0] p, input logic [31:0] im,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic pt, input logic [31:0] ppc);
      drive(op, p, im, a, b, pt, ppc);
      @(posedge clk);
      #1;
      ex_valid = 1'b0;
      bj_op    = 8'h00;
   endtask

   task automatic bht_step(input bit tk, input logic exp_before, input logic exp_after);
      if_pc = 32'h10C;
      drive(OP_BEQ, 32'h10C, 32'h40, 32'd7, tk ? 32'd7 : 32'd8, tk, 32'h14C);
      #1;
      check("bht_read_during_write", 64'(if_pred_taken), 64'(exp_before));
      @(posedge clk);
      #1;
      ex_valid = 1'b0;
      bj_op    = 8'h00;
      check("bht_after_update", 64'(if_pred_taken), 64'(exp_after));
      check("bht_no_redirect", 64'(redirect_valid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; ex_valid = 1'b0; bj_op = 8'h00; pc = '0; imm = '0; rs1 = '0; rs2 = '0;
      pred_taken = 1'b0; pred_pc = '0; redirect_ready = 1'b1; if_pc = 32'h100;
      repeat (2) @(posedge clk);
      #1;
      check("rst_redirect_valid", 64'(redirect_valid), 64'd0);
      check("rst_redirect_pc", 64'(redirect_pc), 64'd0);
      check("rst_misalign", 64'(misalign_err), 64'd0);
      check("rst_cnt", 64'(mispredict_cnt), 64'd0);
      check("rst_stall", 64'(ex_stall), 64'd0);
      check("rst_bht", 64'(if_pred_taken), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // BEQ taken, predicted not-taken -> redirect to 0x120, BHT[0] 01->10
      push_redirect(32'h120);
      issue(OP_BEQ, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'h104);
      check("beq_redirect_valid", 64'(redirect_valid), 64'd1);
      check("beq_cnt", 64'(mispredict_cnt), 64'd1);
      check("beq_bht", 64'(if_pred_taken), 64'd1);
      @(posedge clk); #1;
      check("beq_redirect_drained", 64'(redirect_valid), 64'd0);

      // BLTU -1 < 1 unsigned is false: correct not-taken prediction
      issue(OP_BLTU, 32'h204, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h208);
      check("bltu_no_redirect", 64'(redirect_valid), 64'd0);
      check("bltu_no_stall", 64'(ex_stall), 64'd0);
      check("bltu_cnt", 64'(mispredict_cnt), 64'd1);

      // BLT same operands: signed -1 < 1 is taken
      push_redirect(32'h248);
      issue(OP_BLT, 32'h208, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h20C);
      check("blt_redirect_valid", 64'(redirect_valid), 64'd1);
      check("blt_cnt", 64'(mispredict_cnt), 64'd2);
      @(posedge clk); #1;

      // JALR 0x205 -> 0x204, correctly predicted
      issue(OP_JALR, 32'h300, 32'h0, 32'h205, 32'h0, 1'b1, 32'h204);
      check("jalr_ok_no_redirect", 64'(redirect_valid), 64'd0);
      check("jalr_ok_no_misalign", 64'(misalign_err), 64'd0);

      // JALR targets 0x202 and 0x206 both have bit1 set: misalign pulses only
      push_misalign();
      issue(OP_JALR, 32'h300, 32'h0, 32'h203, 32'h0, 1'b1, 32'h202);
      check("jalr_mis_pulse", 64'(misalign_err), 64'd1);
      push_misalign();
      issue(OP_JALR, 32'h300, 32'h0, 32'h206, 32'h0, 1'b1, 32'h206);
      check("jalr_mis_pulse2", 64'(misalign_err), 64'd1);
      check("jalr_mis_no_redirect", 64'(redirect_valid), 64'd0);
      // Misaligned conditional branch on the BHT test index: no update, no count
      push_misalign();
      issue(OP_BEQ, 32'h10C, 32'h2, 32'd9, 32'd9, 1'b0, 32'h110);
      check("beq_mis_no_redirect", 64'(redirect_valid), 64'd0);
      @(posedge clk); #1;
      check("mis_single_pulse", 64'(misalign_err), 64'd0);
      check("mis_cnt", 64'(mispredict_cnt), 64'd2);

      // Redirect held under backpressure; second branch waits for the ready cycle
      redirect_ready = 1'b0;
      push_redirect(32'h410);
      issue(OP_BNE, 32'h400, 32'h10, 32'd1, 32'd2, 1'b0, 32'h404);
      push_redirect(32'h508);
      drive(OP_BGE, 32'h500, 32'h8, 32'd5, 32'd3, 1'b0, 32'h504);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_high", 64'(ex_stall), 64'd1);
         check("stall_pc_stable", 64'(redirect_pc), 64'h410);
         check("stall_cnt_hold", 64'(mispredict_cnt), 64'd3);
         @(posedge clk); #1;
      end
      redirect_ready = 1'b1;
      #1;
      check("ready_stall_low", 64'(ex_stall), 64'd0);
      @(posedge clk); #1;
      ex_valid = 1'b0; bj_op = 8'h00; redirect_ready = 1'b0;
      check("b2b_valid_kept", 64'(redirect_valid), 64'd1);
      check("b2b_new_pc", 64'(redirect_pc), 64'h508);
      check("b2b_cnt", 64'(mispredict_cnt), 64'd4);
      @(posedge clk); #1;
      check("b2b_valid_held", 64'(redirect_valid), 64'd1);
      redirect_ready = 1'b1;
      @(posedge clk); #1;
      check("b2b_drained", 64'(redirect_valid), 64'd0);

      // BHT saturation and same-cycle read of the entry being written
      bht_step(1'b1, 1'b0, 1'b1);
      bht_step(1'b1, 1'b1, 1'b1);
      bht_step(1'b1, 1'b1, 1'b1);
      bht_step(1'b1, 1'b1, 1'b1);
      bht_step(1'b0, 1'b1, 1'b1);
      bht_step(1'b0, 1'b1, 1'b0);
      bht_step(1'b0, 1'b0, 1'b0);
      bht_step(1'b1, 1'b0, 1'b0);
      bht_step(1'b1, 1'b0, 1'b1);
      check("bht_cnt_unchanged", 64'(mispredict_cnt), 64'd4);

      // Asynchronous reset while a redirect is pending drops it
      redirect_ready = 1'b0;
      issue(OP_BLTU, 32'h600, 32'h20, 32'd1, 32'd2, 1'b0, 32'h604);
      check("pre_rst_valid", 64'(redirect_valid), 64'd1);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 64'(redirect_valid), 64'd0);
      check("arst_pc", 64'(redirect_pc), 64'd0);
      check("arst_cnt", 64'(mispredict_cnt), 64'd0);
      redirect_ready = 1'b1;
      for (int i = 0; i < 64; i++) begin
         if_pc = 32'(i) << 2;
         #1;
         check("arst_bht", 64'(if_pred_taken), 64'd0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
